multicycle_shift_unit: RTL
==========================

# multicycle_shift_unit

Parametrised iterative shifter, successor to the single-cycle processor's combinational SRA path. It supports logical left, logical right, arithmetic right and rotate right on a WIDTH-bit operand, shifting STEP bits per clock. It sits beside the ALU as a multi-cycle functional unit, with a start/busy/done handshake the control unit uses to stall. It also provides carry-out and zero flags.

## Interface
- WIDTH, 32: operand/result width; power of two, ≥ 4.
- STEP, 1: bits shifted per cycle; power of two, 1 ≤ STEP ≤ WIDTH/2.
- SW, $clog2(WIDTH): shift-amount width (derived, not overridden).
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only while busy=0.
- op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- operand  in  WIDTH  value to shift.
- shamt  in  SW  shift amount, 0..WIDTH-1.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  one-cycle pulse when a new result is valid.
- result  out  WIDTH  registered result; holds until the next completion.
- carry  out  1  last bit shifted/rotated out; 0 when shamt=0.
- zero  out  1  result == 0; registered with result.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: if start=1, latch operand into acc, op, rem=shamt, and clear the internal carry.
  - rem=0: go to DONE.
  - rem>0: go to SHIFT.
- SHIFT: each cycle, k = min(STEP, rem); shift acc by k per op; carry ← last bit moved out; rem ← rem−k. When rem−k = 0, go to DONE.
- DONE: result ← acc, carry/zero outputs updated, done=1, go to IDLE.
- SLL: zero fill. Carry = operand[WIDTH−shamt].
- SRL: zero fill. Carry = operand[shamt−1].
- SRA: fill with operand[WIDTH−1]. Carry = operand[shamt−1].
- ROR: bits leaving the LSB re-enter the MSB. Carry = final result[WIDTH−1].
- start while busy=1, including the DONE cycle, is ignored and not queued.
- Inputs are read only at acceptance; later changes to operand/shamt/op have no effect.
- The partial shift of the last step (rem < STEP) must be exact: no over-shift and no wrap of rem.

## Timing
- Reset values: busy=0, done=0, result=0, carry=0, zero=1. State=IDLE, rem=0.
- N = ceil(shamt/STEP). Start sampled high at cycle 0 (busy=0).
  - N SHIFT cycles run in cycles 1..N.
  - done=1 in cycle N+1, and result/carry/zero are valid from that cycle.
  - busy=1 in cycles 1..N+1.
- shamt=0: done in cycle 1, result=operand.
- Earliest next acceptance: start high in cycle N+1 is ignored; start in cycle N+2 is accepted.
- rst=1 during SHIFT or DONE:
  - aborts the operation;
  - done is not asserted;
  - all outputs return to reset values at the next edge.
- rst has priority over start in the same cycle.

## Test plan
- WIDTH=32, STEP=1, SRA, operand=0x80000010, shamt=4 -> done in cycle 5, result=0xF8000001, carry=0, zero=0, busy high cycles 1–5.
- Same operand with SRL, shamt=4 -> result=0x08000001, carry=0. Same operand with SRA, shamt=5 -> result=0xFC000000, carry=1.
- STEP=4:
  - ROR 0x0000000F, shamt=4 -> done in cycle 2, result=0xF0000000, carry=1.
  - SLL 0xFFFFFFFF, shamt=31 -> done in cycle 9, result=0x80000000, carry=1.
- shamt=0, any op, operand=0x0 -> done in cycle 1, result=0, carry=0, zero=1.
- Start accepted, then start re-pulsed with new operand during SHIFT and during DONE -> both ignored, the first result is unchanged, and a start in cycle N+2 is accepted.
- rst=1 in the 3rd SHIFT cycle of SRA shamt=20 (STEP=1) -> no done pulse, busy=0 and result=0 next cycle, and a following SLL 1 by 1 gives result=2 in cycle 2.

Source files
------------

// File: rtl/multicycle_shift_unit.sv
// multicycle_shift_unit: iterative SLL/SRL/SRA/ROR shifter moving STEP bits per clock with start/busy/done handshake
module multicycle_shift_unit #(
  parameter int WIDTH = 32,
  parameter int STEP = 1,
  localparam int SW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand,
  input  logic [SW-1:0]    shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  localparam logic [SW-1:0] STP = SW'(STEP);
  state_t state, state_n;
  logic [WIDTH-1:0] acc, acc_n, sra, rot, sh;
  logic [SW-1:0] rem, rem_n, k, kl, kr;
  logic [1:0] opr, opr_n;
  logic c, c_n, sc;
  always_comb begin
    k = rem < STP ? rem : STP;
    kl = SW'(0) - k;
    kr = k - SW'(1);
    sra = $signed(acc) >>> k;
    rot = WIDTH'({acc, acc} >> k);
    sh = opr == 2'd0 ? acc << k : opr == 2'd1 ? acc >> k : opr == 2'd2 ? sra : rot;
    sc = opr == 2'd0 ? acc[kl] : acc[kr];
    state_n = state;
    acc_n = acc;
    rem_n = rem;
    opr_n = opr;
    c_n = c;
    case (state)
      IDLE: if (start) begin
        acc_n = operand;
        opr_n = op;
        rem_n = shamt;
        c_n = 1'b0;
        state_n = shamt == '0 ? DONE : SHIFT;
      end
      SHIFT: begin
        acc_n = sh;
        c_n = sc;
        rem_n = rem - k;
        state_n = rem == k ? DONE : SHIFT;
      end
      default: state_n = IDLE;
    endcase
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      rem <= '0;
      opr <= '0;
      c <= 1'b0;
      result <= '0;
      carry <= 1'b0;
      zero <= 1'b1;
    end else begin
      state <= state_n;
      acc <= acc_n;
      rem <= rem_n;
      opr <= opr_n;
      c <= c_n;
      if (state_n == DONE && state != DONE) begin
        result <= acc_n;
        carry <= c_n;
        zero <= acc_n == '0;
      end
    end
  end
endmodule
